// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
//   imem_ld_state_t : loader FSM states
//   IMEM_WORD_BYTES : bytes packed into one instruction word
//   IMEM_LEN_BYTES  : bytes in the little-endian word-count prefix
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN0  = 3'd1,
      LEN1  = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      DRAIN = 3'd5,
      DONE  = 3'd6,
      ERR   = 3'd7
   } imem_ld_state_t;

   localparam int IMEM_WORD_BYTES = 4;
   localparam int IMEM_LEN_BYTES  = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
//   clk, rst       : clock, asynchronous active-low reset
//   clr            : synchronous clear of lane counter and shift register
//   byte_valid     : in_byte is accepted this cycle
//   in_byte        : stream byte
//   word           : {b3,b2,b1,b0}, meaningful while word_valid is high
//   word_valid     : high in the cycle the 4th byte of a word is accepted
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  in_byte,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_LANE = 2'(IMEM_WORD_BYTES - 1);

   logic [1:0]  lane_q;
   logic [23:0] shift_q;

   // Bytes enter at the top and move down, so after b0,b1,b2 the register
   // holds {b2,b1,b0} and the arriving b3 completes the word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane_q  <= '0;
         shift_q <= '0;
      end else if (clr) begin
         lane_q  <= '0;
         shift_q <= '0;
      end else if (byte_valid) begin
         lane_q  <= lane_q + 2'd1;
         shift_q <= {in_byte, shift_q[23:8]};
      end
   end

   assign word_valid = byte_valid && (lane_q == LAST_LANE);
   assign word       = {in_byte, shift_q};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives LEN0, LEN1 (word count N, little-endian), then 4N data bytes
// (each word LSB first) and writes the words to addresses 0..N-1, holding
// the core in reset until the image is in place.
// Optional macro IMEM_LOADER_CHECKSUM_EN: a trailing byte equal to the XOR
// of all data bytes is required, otherwise the load ends in ERR.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : arms a load from IDLE, DONE or ERR
//   in_data/valid/ready : byte stream handshake
//   mem_we/addr/wdata : registered instruction memory write port
//   core_hold         : 1 = core held in reset
//   done / err        : load completed / load aborted
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   localparam int CW = 17;
   localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam imem_ld_state_t FINISH_ST = CSUM;
`else
   localparam imem_ld_state_t FINISH_ST = DRAIN;
`endif

   imem_ld_state_t    state_q;
   logic [7:0]        len_lo_q;
   logic [15:0]       len_q;
   logic [ADDR_W:0]   word_idx_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic          accept;
   logic          arm;
   logic          pk_valid;
   logic          pk_word_valid;
   logic [31:0]   pk_word;
   logic [CW-1:0] n_rx;
   logic [CW-1:0] idx_next;
   logic          last_word;

   assign in_ready  = (state_q == LEN0) || (state_q == LEN1) ||
                      (state_q == DATA) || (state_q == CSUM);
   assign core_hold = (state_q != DONE);
   assign done      = (state_q == DONE);
   assign err       = (state_q == ERR);

   assign accept   = in_valid && in_ready;
   assign arm      = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   assign pk_valid = accept && (state_q == DATA);

   // Word count as it completes in LEN1, widened so N = 2**ADDR_W compares exactly.
   assign n_rx      = {1'b0, in_data, len_lo_q};
   assign idx_next  = CW'(word_idx_q) + CW'(1);
   assign last_word = (idx_next == {1'b0, len_q});

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr        (arm),
      .byte_valid (pk_valid),
      .in_byte    (in_data),
      .word       (pk_word),
      .word_valid (pk_word_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         len_lo_q    <= '0;
         len_q       <= '0;
         word_idx_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         if (pk_word_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= word_idx_q[ADDR_W-1:0];
            mem_wdata_q <= pk_word;
            word_idx_q  <= word_idx_q + 1'b1;
         end

         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state_q    <= LEN0;
                  word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q     <= '0;
`endif
               end
            end
            LEN0: begin
               if (accept) begin
                  len_lo_q <= in_data;
                  state_q  <= LEN1;
               end
            end
            LEN1: begin
               if (accept) begin
                  len_q <= n_rx[15:0];
                  if (n_rx > MAX_WORDS)
                     state_q <= ERR;
                  else if (n_rx == '0)
                     state_q <= FINISH_ST;
                  else
                     state_q <= DATA;
               end
            end
            DATA: begin
               if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ in_data;
`endif
                  if (pk_word_valid && last_word)
                     state_q <= FINISH_ST;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (accept)
                  state_q <= (in_data == csum_q) ? DRAIN : ERR;
            end
`endif
            DRAIN:   state_q <= DONE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk;
   logic              rst;
   logic              start;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              done;
   logic              err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] img [0:3];
   int          wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int          wr_cyc_q  [$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_hold (core_hold),
      .done      (done),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(int'(mem_addr));
         wr_data_q.push_back(mem_wdata);
         wr_cyc_q.push_back(cyc);
         $display("write addr=%0d data=%08h cycle=%0d", mem_addr, mem_wdata, cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   // Presents one byte and returns #1 after the edge at which it was taken.
   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL send_byte: in_ready stayed %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Sends a full image of n words from img; gap inserts one idle cycle after
   // each data byte except the last; start_at pulses start during that gap.
   task automatic load(input int n, input bit gap, input int start_at, input bit csum_bad);
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'h00;
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = img[w][8*k +: 8];
            cs = cs ^ b;
            send_byte(b);
            if (gap && !(w == n - 1 && k == 3)) begin
               if (w * 4 + k == start_at) start = 1'b1;
               @(posedge clk); #1;
               start = 1'b0;
            end
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csum_bad ? (cs ^ 8'h01) : cs);
`else
      if (csum_bad) $display("note: checksum not configured");
`endif
   endtask

   task automatic test_reset();
      vectors++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || core_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: in_ready=%b mem_we=%b core_hold=%b done=%b err=%b, required 0 0 1 0 0",
                  in_ready, mem_we, core_hold, done, err);
      end
      vectors++;
      if (mem_addr !== '0 || mem_wdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_data: mem_addr=%0h mem_wdata=%08h, required 0 0", mem_addr, mem_wdata);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_rate();
      clear_log();
      img[0] = 32'h00200093; img[1] = 32'hFEC00113; img[2] = 32'h00700193;
      pulse_start();
      load(3, 1'b0, -1, 1'b0);
      vectors++;
      if (mem_we !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL full_t1: mem_we=%b done=%b core_hold=%b, required 1 0 1", mem_we, done, core_hold);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || core_hold !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL full_t2: done=%b core_hold=%b mem_we=%b err=%b, required 1 0 0 0", done, core_hold, mem_we, err);
      end
      vectors++;
      if (wr_addr_q.size() != 3) begin
         miscompares++;
         $display("FAIL full_count: %0d writes, required 3", wr_addr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== img[i]) begin
               miscompares++;
               $display("FAIL full_write%0d: addr=%0d data=%08h, required %0d %08h", i, wr_addr_q[i], wr_data_q[i], i, img[i]);
            end
         end
         vectors++;
         if (wr_cyc_q[1] - wr_cyc_q[0] != 4 || wr_cyc_q[2] - wr_cyc_q[1] != 4) begin
            miscompares++;
            $display("FAIL full_spacing: %0d %0d cycles, required 4 4", wr_cyc_q[1] - wr_cyc_q[0], wr_cyc_q[2] - wr_cyc_q[1]);
         end
      end
      $display("test_full_rate done");
   endtask

   task automatic test_stall();
      clear_log();
      img[0] = 32'h00200093; img[1] = 32'hFEC00113; img[2] = 32'h00700193;
      pulse_start();
      // start during a DATA gap must be ignored
      load(3, 1'b1, 5, 1'b0);
      vectors++;
      if (mem_we !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_t1: mem_we=%b done=%b, required 1 0", mem_we, done);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || core_hold !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_t2: done=%b core_hold=%b, required 1 0", done, core_hold);
      end
      vectors++;
      if (wr_addr_q.size() != 3) begin
         miscompares++;
         $display("FAIL stall_count: %0d writes, required 3", wr_addr_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== img[i]) begin
               miscompares++;
               $display("FAIL stall_write%0d: addr=%0d data=%08h, required %0d %08h", i, wr_addr_q[i], wr_data_q[i], i, img[i]);
            end
         end
         vectors++;
         if (wr_cyc_q[1] - wr_cyc_q[0] != 8) begin
            miscompares++;
            $display("FAIL stall_spacing: %0d cycles, required 8", wr_cyc_q[1] - wr_cyc_q[0]);
         end
      end
      $display("test_stall done");
   endtask

   task automatic test_zero_len();
      clear_log();
      pulse_start();
      load(0, 1'b0, -1, 1'b0);
      vectors++;
      if (done !== 1'b0 || core_hold !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_t1: done=%b core_hold=%b in_ready=%b, required 0 1 0", done, core_hold, in_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || core_hold !== 1'b0) begin
         miscompares++;
         $display("FAIL zero_t2: done=%b core_hold=%b, required 1 0", done, core_hold);
      end
      vectors++;
      if (wr_addr_q.size() != 0) begin
         miscompares++;
         $display("FAIL zero_writes: %0d writes, required 0", wr_addr_q.size());
      end
      $display("test_zero_len done");
   endtask

   task automatic test_len_err();
      clear_log();
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h01);   // N = 257 > 256
      vectors++;
      if (err !== 1'b1 || core_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL lenerr_t1: err=%b core_hold=%b in_ready=%b done=%b, required 1 1 0 0", err, core_hold, in_ready, done);
      end
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (err !== 1'b1 || wr_addr_q.size() != 0) begin
         miscompares++;
         $display("FAIL lenerr_hold: err=%b writes=%0d, required 1 0", err, wr_addr_q.size());
      end
      pulse_start();
      vectors++;
      if (err !== 1'b0 || core_hold !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL lenerr_restart: err=%b core_hold=%b in_ready=%b done=%b, required 0 1 1 0", err, core_hold, in_ready, done);
      end
      img[0] = 32'hDEADBEEF;
      load(1, 1'b0, -1, 1'b0);
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || wr_addr_q.size() != 1) begin
         miscompares++;
         $display("FAIL lenerr_reload: done=%b writes=%0d, required 1 1", done, wr_addr_q.size());
      end else begin
         vectors++;
         if (wr_addr_q[0] != 0 || wr_data_q[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lenerr_word: addr=%0d data=%08h, required 0 deadbeef", wr_addr_q[0], wr_data_q[0]);
         end
      end
      $display("test_len_err done");
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      clear_log();
      img[0] = 32'h11223344;
      pulse_start();
      load(1, 1'b0, -1, 1'b0);   // checksum 0x44
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL csum_good: done=%b err=%b, required 1 0", done, err);
      end
      clear_log();
      pulse_start();
      load(1, 1'b0, -1, 1'b1);   // checksum 0x45
      vectors++;
      if (err !== 1'b1 || core_hold !== 1'b1) begin
         miscompares++;
         $display("FAIL csum_bad: err=%b core_hold=%b, required 1 1", err, core_hold);
      end
      vectors++;
      if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'h11223344 || wr_addr_q[0] != 0) begin
         miscompares++;
         $display("FAIL csum_bad_write: writes=%0d, required one write of 11223344 at 0", wr_addr_q.size());
      end
      $display("test_checksum done");
   endtask
`endif

   task automatic test_reset_mid();
      clear_log();
      img[0] = 32'hA1B2C3D4; img[1] = 32'h0F1E2D3C;
      pulse_start();
      send_byte(8'h02);
      send_byte(8'h00);
      for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k));
      in_data  = 8'h55;
      in_valid = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'h0 ||
          core_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset: in_ready=%b mem_we=%b addr=%0h wdata=%08h core_hold=%b done=%b err=%b",
                  in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, err);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      clear_log();
      pulse_start();
      load(2, 1'b0, -1, 1'b0);
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b1 || wr_addr_q.size() != 2) begin
         miscompares++;
         $display("FAIL midreset_reload: done=%b writes=%0d, required 1 2", done, wr_addr_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== img[i]) begin
               miscompares++;
               $display("FAIL midreset_write%0d: addr=%0d data=%08h, required %0d %08h", i, wr_addr_q[i], wr_data_q[i], i, img[i]);
            end
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_full_rate();
      test_stall();
      test_zero_len();
      test_len_err();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
